// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Optional build macro used by this block: MISALIGN_TRAP_EN.
package fetch_pkg;

    // Fetch sequencer FSM states.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    // Sequential PC advance, one 32-bit instruction.
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Canonical RISC-V NOP (addi x0, x0, 0), used as the idle bus value.
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: the only PC storage in the fetch front end.
// Load (redirect) has priority over the sequential increment.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        incr,
    output logic [31:0] pc
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;

    // Next-PC select: redirect target, PC+4 (wraps mod 2^32), or hold.
    always_comb begin
        // NOTE: assigning a default first gives every path a value, so no latch is inferred.
        pc_d = pc_q;
        if (load) begin
            pc_d = load_value;
        end else if (incr) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // PC state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one outstanding instruction fetch,
// handles redirect/drop/stall and presents the fetched word to decode.
// Optional build macro: MISALIGN_TRAP_EN (misaligned redirect -> TRAP_VECTOR
// plus a registered trap pulse; when undefined targets are word-aligned).
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    input  logic        stall,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemValid,
    input  logic [31:0] imemData,
    output logic        instrValid,
    output logic [31:0] instrOut,
    output logic [31:0] instrPC,
    output logic [31:0] pcOut,
    output logic        trap
);

    fetch_state_t state_d, state_q;
    logic         drop_d, drop_q;
    logic         instr_valid_d, instr_valid_q;
    logic [31:0]  instr_out_d, instr_out_q;
    logic [31:0]  instr_pc_d, instr_pc_q;

    logic [31:0]  pc;
    logic [31:0]  redirect_pc;
    logic         pc_incr;
    logic         capture;
    logic         req;
    logic         hold_out;

    fetch_pc_reg #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk        (clock),
        .rst_n      (reset),
        .load       (redirect),
        .load_value (redirect_pc),
        .incr       (pc_incr),
        .pc         (pc)
    );

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    logic trap_d, trap_q;

    assign misaligned  = (redirectTarget[1:0] != 2'b00);
    assign redirect_pc = misaligned ? TRAP_VECTOR : redirectTarget;

    // Trap request: a redirect whose target is not word-aligned.
    always_comb begin
        trap_d = redirect && misaligned;
    end

    // Trap pulse lands in the cycle after the offending redirect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign trap = trap_q;
`else
    logic unused_trap_path;

    assign redirect_pc      = {redirectTarget[31:2], 2'b00};
    assign trap             = 1'b0;
    assign unused_trap_path = ^{redirectTarget[1:0], TRAP_VECTOR};
`endif

    // Presented instruction not yet taken by decode: no new fetch may start,
    // otherwise its response could overwrite the held instruction.
    assign hold_out = instr_valid_q && stall;

    // Next state, drop tracking, fetch request and decode-side registers.
    always_comb begin
        state_d       = state_q;
        drop_d        = drop_q;
        instr_valid_d = instr_valid_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        req           = 1'b0;
        capture       = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                req = !hold_out;
                if (req && imemReady) begin
                    // An accepted request always owes a response; a same-cycle
                    // redirect turns it into the one response to discard.
                    state_d = WAIT;
                    if (redirect) begin
                        drop_d = 1'b1;
                    end
                end else if (redirect) begin
                    state_d = FETCH;
                end else if (hold_out) begin
                    state_d = HOLD;
                end
            end
            WAIT: begin
                if (imemValid) begin
                    drop_d = 1'b0;
                    if (redirect || drop_q) begin
                        state_d = FETCH;
                    end else begin
                        capture = 1'b1;
                        state_d = stall ? HOLD : FETCH;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // Decode-side presentation: redirect > capture > accept-by-decode.
        if (redirect) begin
            instr_valid_d = 1'b0;
        end else if (capture) begin
            instr_valid_d = 1'b1;
            instr_out_d   = imemData;
            instr_pc_d    = pc;
        end else if (instr_valid_q && !stall) begin
            instr_valid_d = 1'b0;
        end
    end

    assign pc_incr = capture;

    // FSM, drop flag and decode output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            drop_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_out_q   <= 32'h0;
            instr_pc_q    <= 32'h0;
        end else begin
            state_q       <= state_d;
            drop_q        <= drop_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign imemReq    = req;
    assign imemAddr   = pc;
    assign pcOut      = pc;
    assign instrValid = instr_valid_q;
    assign instrOut   = instr_out_q;
    assign instrPC    = instr_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized traffic, checked against a transaction-level model of the PC,
// the single outstanding memory request and the instruction shown to decode.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0004;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirectTarget = 32'h0;
    logic        stall = 1'b0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady = 1'b0;
    logic        imemValid = 1'b0;
    logic [31:0] imemData = INSTR_NOP;
    logic        instrValid;
    logic [31:0] instrOut;
    logic [31:0] instrPC;
    logic [31:0] pcOut;
    logic        trap;

    always #5 clock = ~clock;

    fetch_sequencer #(
        .RESET_VECTOR (RESET_VEC),
        .TRAP_VECTOR  (TRAP_VEC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect       (redirect),
        .redirectTarget (redirectTarget),
        .stall          (stall),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemReady      (imemReady),
        .imemValid      (imemValid),
        .imemData       (imemData),
        .instrValid     (instrValid),
        .instrOut       (instrOut),
        .instrPC        (instrPC),
        .pcOut          (pcOut),
        .trap           (trap)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [31:0] m_pc;          // architectural fetch PC
    logic        p_valid;       // instruction presented to decode
    logic [31:0] p_pc, p_data;
    logic        exp_trap;
    bit          mem_busy;      // memory owes a response
    int          mem_left;
    logic [31:0] out_addr, out_data;
    bit          out_killed;    // a redirect happened since the request was accepted
    bit          ovr_en;
    logic [31:0] ovr_data;
    logic [31:0] acc_log[$];
    int          deliveries = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] map_target(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
        return (t[1:0] != 2'b00) ? TRAP_VEC : t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    function automatic logic misaligned(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
        return t[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] last_acc();
        if (acc_log.size() == 0) return 32'hxxxx_xxxx;
        return acc_log[acc_log.size() - 1];
    endfunction

    task automatic model_reset();
        m_pc       = RESET_VEC;
        p_valid    = 1'b0;
        p_pc       = 32'h0;
        p_data     = 32'h0;
        exp_trap   = 1'b0;
        mem_busy   = 1'b0;
        mem_left   = 0;
        out_killed = 1'b0;
        ovr_en     = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check and advance the model, then
    // return 1 ns after the following rising edge.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt,
                         input logic rdy, input int lat);
        logic resp, accepted, capture;
        @(negedge clock);
        resp = 1'b0;
        if (mem_busy) begin
            mem_left--;
            if (mem_left <= 0) begin
                resp     = 1'b1;
                mem_busy = 1'b0;
            end
        end
        imemValid      = resp;
        imemData       = resp ? out_data : INSTR_NOP;
        stall          = st;
        redirect       = rd;
        redirectTarget = tgt;
        imemReady      = rdy;
        #1;
        check("pc_out", pcOut, m_pc);
        check("instr_valid", instrValid, p_valid);
        if (p_valid) begin
            check("instr_pc", instrPC, p_pc);
            check("instr_out", instrOut, p_data);
            if (st) check("no_req_while_stalled", imemReq, 1'b0);
        end
        check("trap", trap, exp_trap);
        if (imemReq) begin
            check("req_addr", imemAddr, m_pc);
            check("single_outstanding", mem_busy, 1'b0);
        end
        accepted = imemReq && imemReady;
        capture  = resp && !out_killed && !rd;
        if (capture) begin
            p_pc   = out_addr;
            p_data = out_data;
        end
        if (accepted) begin
            mem_busy   = 1'b1;
            mem_left   = lat;
            out_addr   = imemAddr;
            out_data   = ovr_en ? ovr_data : mem_word(imemAddr);
            ovr_en     = 1'b0;
            out_killed = 1'b0;
            acc_log.push_back(imemAddr);
        end
        if (rd) out_killed = 1'b1;
        exp_trap = rd && misaligned(tgt);
        if (p_valid && !st) deliveries++;
        if (rd) begin
            m_pc    = map_target(tgt);
            p_valid = 1'b0;
        end else if (capture) begin
            m_pc    = m_pc + 32'd4;
            p_valid = 1'b1;
        end else if (p_valid && !st) begin
            p_valid = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_until_accept(input int lat);
        int  n;
        bit  ok;
        n  = acc_log.size();
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, lat);
            if (acc_log.size() > n) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", ok, 1'b1);
    endtask

    // Asynchronous reset mid-cycle: outputs must reach reset values before
    // any clock edge; then one BOOT cycle without a request.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_pc_out"}, pcOut, RESET_VEC);
        check({tag, "_instr_valid"}, instrValid, 1'b0);
        check({tag, "_instr_out"}, instrOut, 32'h0);
        check({tag, "_instr_pc"}, instrPC, 32'h0);
        check({tag, "_imem_req"}, imemReq, 1'b0);
        check({tag, "_trap"}, trap, 1'b0);
        model_reset();
        @(negedge clock);
        reset     = 1'b1;
        imemValid = 1'b0;
        redirect  = 1'b0;
        #1;
        check({tag, "_boot_no_req"}, imemReq, 1'b0);
    endtask

    initial begin
        logic [31:0] held_pc;
        model_reset();
        #2;
        do_reset("por");

        // 1: zero-wait memory, sequential addresses 0,4,8,C.
        acc_log.delete();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
        check("seq_addr0", acc_log[0], 32'h0);
        check("seq_addr1", acc_log[1], 32'h4);
        check("seq_addr2", acc_log[2], 32'h8);
        check("seq_addr3", acc_log[3], 32'hC);

        // 2: stall holds the presented instruction, then fetch resumes at +4.
        ovr_en   = 1'b1;
        ovr_data = 32'h00A0_0093;
        for (int i = 0; i < 12; i++) begin
            if (p_valid && p_data == 32'h00A0_0093) break;
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1);
        check("stall_instr_out", instrOut, 32'h00A0_0093);
        check("stall_valid", instrValid, 1'b1);
        held_pc = instrPC;
        run_until_accept(1);
        check("after_stall_addr", last_acc(), held_pc + 32'd4);

        // 3: redirect during WAIT, DEADBEEF arrives 2 cycles later and is dropped.
        ovr_en   = 1'b1;
        ovr_data = 32'hDEAD_BEEF;
        run_until_accept(3);
        cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
        check("drop_no_valid", instrValid, 1'b0);
        run_until_accept(1);
        check("redirect_addr", last_acc(), 32'h0000_0100);

        // 4: redirect in the same cycle as the response.
        run_until_accept(1);
        cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1);
        check("same_cycle_pc", pcOut, 32'h0000_0200);
        check("same_cycle_no_valid", instrValid, 1'b0);
        run_until_accept(1);
        check("same_cycle_addr", last_acc(), 32'h0000_0200);

        // 5: PC wrap from FFFF_FFFC to 0.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1);
        run_until_accept(1);
        check("wrap_fetch_addr", last_acc(), 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
        check("wrap_pc", pcOut, 32'h0);
        check("wrap_instr_pc", instrPC, 32'hFFFF_FFFC);
        run_until_accept(1);
        check("wrap_next_addr", last_acc(), 32'h0);

        // 6: async reset while waiting for memory, and while holding for decode.
        run_until_accept(3);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
        #2;
        do_reset("rst_wait");
        run_until_accept(1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1);
        check("hold_before_reset", instrValid, 1'b1);
        #2;
        do_reset("rst_hold");

`ifdef MISALIGN_TRAP_EN
        cycle(1'b0, 1'b1, 32'h0000_0102, 1'b1, 1);
        check("trap_pulse", trap, 1'b1);
        check("trap_pc", pcOut, TRAP_VEC);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
        check("trap_one_cycle", trap, 1'b0);
`endif

        // Randomized traffic.
        deliveries = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6, tgt,
                  $urandom_range(0, 99) < 70, $urandom_range(1, 3));
        end
        check("progress", (deliveries >= 100) ? 1'b1 : 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
